// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and the
// oversampling tick divider used by both ends of the link.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int uart_div(input int clk_freq, input int baud, input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Generic two-flop synchronizer; resets to RESET_VAL (idle-high line by default).
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_p0 <= RESET_VAL;
      q       <= RESET_VAL;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, 8 data bits LSB first, one stop bit, 3-sample mid-bit vote.
// Define UART_RX_PARITY_EN for 8E1 frames with parity checking; otherwise 8N1.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_rx,
  output logic                 valid_rx,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 busy
);

  localparam int DIV    = uart_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int MID    = OVERSAMPLE / 2;
  localparam int TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SAMP_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  if (DIV < 2) begin : g_div_check
    $error("uart_rx_os: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 2");
  end
  if ((OVERSAMPLE < 4) || ((OVERSAMPLE % 2) != 0)) begin : g_os_check
    $error("uart_rx_os: OVERSAMPLE must be even and at least 4");
  end

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  rx_state_t            state;
  rx_state_t            state_next;
  logic                 rx_p1;
  logic                 rx_p2;
  logic                 start_edge;
  logic [TICK_W-1:0]    tick_cnt;
  logic [SAMP_W-1:0]    samp_cnt;
  logic                 tick;
  logic                 vote_time;
  logic                 samp_a;
  logic                 samp_b;
  logic                 vote;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 last_bit;
  logic [DATA_BITS-1:0] shift;
  logic                 valid_next;
  logic                 ferr_next;

  // Stage p1: synchronized line; stage p2: history for falling-edge detection
  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_in),
    .q     (rx_p1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) rx_p2 <= 1'b1;
    else        rx_p2 <= rx_p1;
  end

  assign start_edge = rx_p2 & ~rx_p1;

  // Tick and sample counters idle at zero so every frame is timed from its own start edge
  assign tick = (tick_cnt == TICK_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE) begin
      tick_cnt <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
      samp_cnt <= (samp_cnt == SAMP_W'(OVERSAMPLE - 1)) ? '0 : samp_cnt + SAMP_W'(1);
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tick && samp_cnt == SAMP_W'(MID - 1)) samp_a <= rx_p1;
    if (tick && samp_cnt == SAMP_W'(MID))     samp_b <= rx_p1;
  end

  assign vote_time = tick && (samp_cnt == SAMP_W'(MID + 1));
  assign vote      = maj3(samp_a, samp_b, rx_p1);

  always_ff @(posedge clk) begin
    if (!rst_n || state != DATA) bit_cnt <= '0;
    else if (vote_time)          bit_cnt <= bit_cnt + BIT_W'(1);
  end

  assign last_bit = (bit_cnt == BIT_W'(DATA_BITS - 1));

  always_ff @(posedge clk) begin
    if (state == DATA && vote_time) shift <= {vote, shift[DATA_BITS-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    valid_next = 1'b0;
    ferr_next  = 1'b0;
    case (state)
      IDLE: begin
        if (start_edge) state_next = START;
      end
      START: begin
        if (vote_time) state_next = vote ? IDLE : DATA;
      end
      DATA: begin
        if (vote_time && last_bit) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (vote_time) state_next = STOP;
      end
`endif
      STOP: begin
        if (vote_time) begin
          state_next = IDLE;
          valid_next = vote;
          ferr_next  = ~vote;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output stage: pulses land in the same cycle the FSM is back in IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_rx  <= 1'b0;
      frame_err <= 1'b0;
      data_rx   <= '0;
    end else begin
      valid_rx  <= valid_next;
      frame_err <= ferr_next;
      if (valid_next) data_rx <= shift;
    end
  end

  assign busy = (state != IDLE);

`ifdef UART_RX_PARITY_EN
  logic par_bad;
  logic perr_q;

  // Even parity: the parity bit makes the total count of ones even
  always_ff @(posedge clk) begin
    if (!rst_n || state == IDLE)         par_bad <= 1'b0;
    else if (state == PARITY && vote_time) par_bad <= vote ^ (^shift);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= valid_next & par_bad;
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os at DIV=2 (32 clk per bit); follows UART_RX_PARITY_EN.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 32;
  localparam int MAX_CLK  = 100000;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int PERR_TOTAL = 1;
`else
  localparam int FRAME_BITS = 10;
  localparam int PERR_TOTAL = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_in;
  logic [7:0] data_rx;
  logic       valid_rx;
  logic       frame_err;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int perr_with_valid = 0;
  int both_cnt = 0;
  int busy_bad = 0;
  logic prev_busy = 1'b0;
  int vtimes[$];
  logic [7:0] vdata[$];

  int v0, f0, p0, pv0, n;

  always #5 clk = ~clk;

  uart_rx_os #(
    .CLK_FREQ   (3_200_000),
    .BAUD       (100_000),
    .OVERSAMPLE (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_in      (rx_in),
    .data_rx    (data_rx),
    .valid_rx   (valid_rx),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (valid_rx) begin
      valid_cnt = valid_cnt + 1;
      vtimes.push_back(cyc);
      vdata.push_back(data_rx);
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (parity_err) perr_cnt = perr_cnt + 1;
    if (parity_err && valid_rx) perr_with_valid = perr_with_valid + 1;
    if (valid_rx && frame_err) both_cnt = both_cnt + 1;
    if ((valid_rx || frame_err) && (busy || !prev_busy)) busy_bad = busy_bad + 1;
    prev_busy = busy;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic snap();
    v0  = valid_cnt;
    f0  = ferr_cnt;
    p0  = perr_cnt;
    pv0 = perr_with_valid;
  endtask

  task automatic send_byte(input logic [7:0] b, input int bclk, input logic stop_v,
                           input logic par_flip, input int max_clk);
    logic [10:0] bits;
    int nbits;
    int k;
    k = 0;
`ifdef UART_RX_PARITY_EN
    bits  = {stop_v, (^b) ^ par_flip, b, 1'b0};
    nbits = 11;
`else
    bits  = {(^b) ^ par_flip, stop_v, b, 1'b0};
    nbits = 10;
`endif
    for (int i = 0; i < nbits; i++) begin
      rx_in = bits[i];
      repeat (bclk) begin
        if (k >= max_clk) return;
        @(negedge clk);
        k = k + 1;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_data", 32'(data_rx), 32'h0);
    chk("rst_valid", 32'(valid_rx), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_perr", 32'(parity_err), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    snap();
    send_byte(8'hA5, BIT_CLKS, 1'b1, 1'b0, MAX_CLK);
    repeat (40) @(negedge clk);
    chk("a5_valid", valid_cnt - v0, 1);
    chk("a5_ferr", ferr_cnt - f0, 0);
    chk("a5_perr", perr_cnt - p0, 0);
    chk("a5_data", 32'(data_rx), 32'hA5);
    chk("a5_busy", 32'(busy), 0);

    snap();
    send_byte(8'h00, BIT_CLKS, 1'b1, 1'b0, MAX_CLK);
    send_byte(8'hFF, BIT_CLKS, 1'b1, 1'b0, MAX_CLK);
    repeat (40) @(negedge clk);
    n = vtimes.size();
    chk("b2b_valid", valid_cnt - v0, 2);
    chk("b2b_sep", (n >= 2) ? vtimes[n-1] - vtimes[n-2] : 0, FRAME_BITS * BIT_CLKS);
    chk("b2b_first", (n >= 2) ? 32'(vdata[n-2]) : 32'hDEAD, 32'h00);
    chk("b2b_data", 32'(data_rx), 32'hFF);

    snap();
    rx_in = 1'b0;
    repeat (6) @(negedge clk);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 1);
    repeat (16) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 0);
    chk("glitch_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);

    snap();
    send_byte(8'h3C, BIT_CLKS, 1'b0, 1'b0, MAX_CLK);
    rx_in = 1'b0;
    repeat (2000) @(negedge clk);
    chk("brk_ferr", ferr_cnt - f0, 1);
    chk("brk_valid", valid_cnt - v0, 0);
    chk("brk_data", 32'(data_rx), 32'hFF);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    chk("brk_ferr_once", ferr_cnt - f0, 1);
    chk("brk_busy", 32'(busy), 0);

    snap();
    send_byte(8'h55, BIT_CLKS - 1, 1'b1, 1'b0, MAX_CLK);
    repeat (40) @(negedge clk);
    chk("fast_valid", valid_cnt - v0, 1);
    chk("fast_data", 32'(data_rx), 32'h55);
    snap();
    send_byte(8'h55, BIT_CLKS + 1, 1'b1, 1'b0, MAX_CLK);
    repeat (40) @(negedge clk);
    chk("slow_valid", valid_cnt - v0, 1);
    chk("slow_data", 32'(data_rx), 32'h55);

    snap();
    send_byte(8'h81, BIT_CLKS, 1'b1, 1'b0, 182);
    rst_n = 1'b0;
    rx_in = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rstmid_pulses", (valid_cnt - v0) + (ferr_cnt - f0), 0);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_data", 32'(data_rx), 32'h0);
    snap();
    send_byte(8'h81, BIT_CLKS, 1'b1, 1'b0, MAX_CLK);
    repeat (40) @(negedge clk);
    chk("rstmid_valid", valid_cnt - v0, 1);
    chk("rstmid_rx", 32'(data_rx), 32'h81);

`ifdef UART_RX_PARITY_EN
    snap();
    send_byte(8'h07, BIT_CLKS, 1'b1, 1'b1, MAX_CLK);
    repeat (40) @(negedge clk);
    chk("par_valid", valid_cnt - v0, 1);
    chk("par_err", perr_cnt - p0, 1);
    chk("par_same_cycle", perr_with_valid - pv0, 1);
    chk("par_data", 32'(data_rx), 32'h07);
`endif

    chk("perr_total", perr_cnt, PERR_TOTAL);
    chk("valid_ferr_overlap", both_cnt, 0);
    chk("busy_at_pulse", busy_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
